// File: rtl/mlcd_pkg.sv
// mlcd_pkg: shared state encoding, pixel width and default panel geometry
// for the memory-LCD scan sequencer.
package mlcd_pkg;

    localparam int RGB_W       = 6;
    localparam int H_WORDS_DEF = 240;
    localparam int V_LINES_DEF = 320;

    // Bit replicated across a pixel word to paint white when the FIFO runs dry
    localparam logic FILL_WHITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INTB = 3'd1,
        GSP  = 3'd2,
        LINE = 3'd3,
        DATA = 3'd4,
        GEN  = 3'd5,
        TAIL = 3'd6
    } state_t;

endpackage

// File: rtl/mlcd_tick_gen.sv
// mlcd_tick_gen: divide-by-DIV prescaler producing a one-clock timing tick
// (tick is high while the count sits at DIV-1).
module mlcd_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV - 2);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Free-running prescaler; tick_r is registered one count early so it lines up with DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/mlcd_scan_sequencer.sv
// mlcd_scan_sequencer: scans one memory-LCD frame per request, popping pixel
// words from a first-word-fall-through FIFO and sequencing INTB/GSP/GCK/BSP/
// BCK/GEN/RGB. All state and pin changes happen on prescaler ticks.
// Optional build macro MLCD_UNDERRUN_FILL_EN: an empty FIFO during DATA paints
// white instead of stalling and raises the sticky o_underrun flag.
module mlcd_scan_sequencer #(
    parameter int H_WORDS   = mlcd_pkg::H_WORDS_DEF,
    parameter int V_LINES   = mlcd_pkg::V_LINES_DEF,
    parameter int DIV       = 4,
    parameter int GEN_TICKS = 2,
    parameter int RGB_W     = mlcd_pkg::RGB_W
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_frame_req,
    input  logic [RGB_W-1:0] i_fifo_rdata,
    input  logic             i_fifo_rempty,
    output logic             o_fifo_rd,
    output logic             o_intb,
    output logic             o_gsp,
    output logic             o_gck,
    output logic             o_gen,
    output logic             o_bsp,
    output logic             o_bck,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_stall,
    output logic             o_underrun
);

    import mlcd_pkg::*;

    localparam int            WW        = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam int            LW        = $clog2(V_LINES + 1);
    localparam int            GW        = (GEN_TICKS > 1) ? $clog2(GEN_TICKS) : 1;
    localparam logic [WW-1:0] WORD_LAST = WW'(H_WORDS - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES);
    localparam logic [GW-1:0] GEN_LAST  = GW'(GEN_TICKS - 1);

`ifdef MLCD_UNDERRUN_FILL_EN
    localparam logic FILL_EN = 1'b1;
`else
    localparam logic FILL_EN = 1'b0;
`endif

    state_t           state_r, state_nxt_s;
    logic             tick_s, start_s, advance_s, word_last_s, gen_last_s;
    logic [WW-1:0]    word_r, word_nxt_s;
    logic [LW-1:0]    line_r, line_nxt_s, line_inc_s;
    logic [GW-1:0]    gcnt_r, gcnt_nxt_s;
    logic             tail_r, tail_nxt_s;
    logic             intb_r, gsp_r, gck_r, gen_r, bsp_r, bck_r;
    logic             intb_nxt_s, gsp_nxt_s, gck_nxt_s, gen_nxt_s, bsp_nxt_s, bck_nxt_s;
    logic [RGB_W-1:0] rgb_r, rgb_nxt_s;

    mlcd_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .tick  (tick_s)
    );

    assign start_s     = i_frame_req & ~i_fifo_rempty;
    assign advance_s   = ~i_fifo_rempty | FILL_EN;
    assign word_last_s = (word_r == WORD_LAST);
    assign gen_last_s  = (gcnt_r == GEN_LAST);
    assign line_inc_s  = line_r + LW'(1);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode, evaluated only on tick clocks
    always_comb begin
        state_nxt_s = state_r;
        if (tick_s) begin
            case (state_r)
                IDLE: if (start_s) state_nxt_s = INTB; else state_nxt_s = IDLE;
                INTB: state_nxt_s = GSP;
                GSP:  state_nxt_s = LINE;
                LINE: state_nxt_s = DATA;
                DATA: if (advance_s && word_last_s) state_nxt_s = GEN; else state_nxt_s = DATA;
                GEN: begin
                    if (!gen_last_s)                  state_nxt_s = GEN;
                    else if (line_inc_s == LINE_LAST) state_nxt_s = TAIL;
                    else                              state_nxt_s = LINE;
                end
                TAIL: if (tail_r) state_nxt_s = IDLE; else state_nxt_s = TAIL;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of pins and counters; everything holds between ticks and while stalled
    always_comb begin
        intb_nxt_s = intb_r;
        gsp_nxt_s  = gsp_r;
        gck_nxt_s  = gck_r;
        gen_nxt_s  = gen_r;
        bsp_nxt_s  = bsp_r;
        bck_nxt_s  = bck_r;
        rgb_nxt_s  = rgb_r;
        word_nxt_s = word_r;
        line_nxt_s = line_r;
        gcnt_nxt_s = gcnt_r;
        tail_nxt_s = tail_r;
        if (tick_s) begin
            case (state_r)
                IDLE: if (start_s) intb_nxt_s = 1'b1; else intb_nxt_s = intb_r;
                INTB: gsp_nxt_s = 1'b1;
                GSP:  line_nxt_s = {LW{1'b0}};
                LINE: begin
                    gck_nxt_s  = ~gck_r;
                    word_nxt_s = {WW{1'b0}};
                    if (line_r == {LW{1'b0}}) gsp_nxt_s = 1'b0; else gsp_nxt_s = gsp_r;
                end
                DATA: begin
                    if (!i_fifo_rempty) rgb_nxt_s = i_fifo_rdata;
                    else if (FILL_EN)   rgb_nxt_s = {RGB_W{FILL_WHITE}};
                    else                rgb_nxt_s = rgb_r;
                    if (advance_s) begin
                        bsp_nxt_s = (word_r == {WW{1'b0}});
                        if (word_r != {WW{1'b0}}) bck_nxt_s = ~bck_r; else bck_nxt_s = bck_r;
                        if (word_last_s) begin
                            gen_nxt_s  = 1'b1;
                            gcnt_nxt_s = {GW{1'b0}};
                        end else begin
                            word_nxt_s = word_r + WW'(1);
                        end
                    end else begin
                        bsp_nxt_s = bsp_r;
                    end
                end
                GEN: begin
                    bsp_nxt_s = 1'b0;
                    if (gen_last_s) begin
                        gen_nxt_s  = 1'b0;
                        line_nxt_s = line_inc_s;
                        tail_nxt_s = 1'b0;
                    end else begin
                        gcnt_nxt_s = gcnt_r + GW'(1);
                    end
                end
                TAIL: begin
                    if (!tail_r) begin
                        gck_nxt_s  = ~gck_r;
                        tail_nxt_s = 1'b1;
                    end else begin
                        intb_nxt_s = 1'b0;
                        gck_nxt_s  = 1'b0;
                        bck_nxt_s  = 1'b0;
                        tail_nxt_s = 1'b0;
                    end
                end
                default: begin
                    intb_nxt_s = 1'b0;
                    gsp_nxt_s  = 1'b0;
                    gck_nxt_s  = 1'b0;
                    gen_nxt_s  = 1'b0;
                    bsp_nxt_s  = 1'b0;
                    bck_nxt_s  = 1'b0;
                end
            endcase
        end else begin
            rgb_nxt_s = rgb_r;
        end
    end

    // Pin and counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            intb_r <= 1'b0;
            gsp_r  <= 1'b0;
            gck_r  <= 1'b0;
            gen_r  <= 1'b0;
            bsp_r  <= 1'b0;
            bck_r  <= 1'b0;
            rgb_r  <= {RGB_W{1'b0}};
            word_r <= {WW{1'b0}};
            line_r <= {LW{1'b0}};
            gcnt_r <= {GW{1'b0}};
            tail_r <= 1'b0;
        end else begin
            intb_r <= intb_nxt_s;
            gsp_r  <= gsp_nxt_s;
            gck_r  <= gck_nxt_s;
            gen_r  <= gen_nxt_s;
            bsp_r  <= bsp_nxt_s;
            bck_r  <= bck_nxt_s;
            rgb_r  <= rgb_nxt_s;
            word_r <= word_nxt_s;
            line_r <= line_nxt_s;
            gcnt_r <= gcnt_nxt_s;
            tail_r <= tail_nxt_s;
        end
    end

`ifdef MLCD_UNDERRUN_FILL_EN
    logic underrun_r;

    // Sticky underrun: set on every white-filled word, cleared when a new frame starts
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            underrun_r <= 1'b0;
        end else if (tick_s && (state_r == IDLE) && start_s) begin
            underrun_r <= 1'b0;
        end else if (tick_s && (state_r == DATA) && i_fifo_rempty) begin
            underrun_r <= 1'b1;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign o_underrun = underrun_r;
`else
    assign o_underrun = 1'b0;
`endif

    // Pop and done strobes must land in the tick clock itself (FWFT handshake)
    assign o_fifo_rd    = tick_s & (state_r == DATA) & ~i_fifo_rempty;
    assign o_frame_done = tick_s & (state_r == TAIL) & tail_r;
    assign o_stall      = (state_r == DATA) & i_fifo_rempty & ~FILL_EN;
    assign o_busy       = (state_r != IDLE);

    assign o_intb = intb_r;
    assign o_gsp  = gsp_r;
    assign o_gck  = gck_r;
    assign o_gen  = gen_r;
    assign o_bsp  = bsp_r;
    assign o_bck  = bck_r;
    assign o_rgb  = rgb_r;

endmodule

// File: tb/tb_mlcd_scan_sequencer.sv
// tb_mlcd_scan_sequencer: directed frames on a 4x3 panel with DIV=2; stimulus
// pushes expected pixels and per-frame totals, a monitor pops and compares.
module tb_mlcd_scan_sequencer;

    localparam int HW = 4;
    localparam int VL = 3;
    localparam int DV = 2;
    localparam int GT = 2;
    localparam int RW = 6;

    typedef struct {
        int len; int gck; int bck; int bsp; int gen; int pops; int stall; int und;
    } frame_t;

    logic          clk, rst_n, req, rempty;
    logic [RW-1:0] rdata, rgb;
    logic          fifo_rd, intb, gsp, gck, gen, bsp, bck, busy, done, stall, underrun;

    logic [RW-1:0] fifo_q[$];
    logic [RW-1:0] pix_q[$];
    frame_t        frm_q[$];
    int            gap_q[$];

    int checks = 0;
    int errors = 0;
    int pop_total = 0;
    int block_at = -1;
    int block_cnt = 0;
    bit pix_en = 1'b1;

    logic intb_p = 1'b0, gck_p = 1'b0, bck_p = 1'b0, bsp_p = 1'b0, gen_p = 1'b0;
    int   len = 0, n_gck = 0, n_bck = 0, n_bsp = 0, n_gen = 0, n_pop = 0, n_stall = 0, gap = 0;

    mlcd_scan_sequencer #(
        .H_WORDS(HW), .V_LINES(VL), .DIV(DV), .GEN_TICKS(GT), .RGB_W(RW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_frame_req  (req),
        .i_fifo_rdata (rdata),
        .i_fifo_rempty(rempty),
        .o_fifo_rd    (fifo_rd),
        .o_intb       (intb),
        .o_gsp        (gsp),
        .o_gck        (gck),
        .o_gen        (gen),
        .o_bsp        (bsp),
        .o_bck        (bck),
        .o_rgb        (rgb),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_stall      (stall),
        .o_underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load(input int first, input int n, input bit expect_pix);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(RW'(first + i));
            if (expect_pix) pix_q.push_back(RW'(first + i));
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic push_frame(input int l, input int pops, input int stl, input int und);
        frame_t f;
        f.len = l; f.gck = VL + 1; f.bck = VL * (HW - 1); f.bsp = VL; f.gen = VL;
        f.pops = pops; f.stall = stl; f.und = und;
        frm_q.push_back(f);
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 req = 1'b1;
        repeat (DV) @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check(name, int'(n < budget), 1);
    endtask

    // FWFT FIFO model: pop applied just after the edge on which the DUT strobed
    initial begin : fifo_model
        logic rd;
        rempty = 1'b1;
        rdata  = '0;
        forever begin
            @(negedge clk);
            rd = fifo_rd;
            @(posedge clk);
            #1;
            if (block_cnt > 0) block_cnt--;
            if (rd && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pop_total++;
                if (pop_total == block_at) block_cnt = 6;
            end
            rempty = (fifo_q.size() == 0) || (block_cnt > 0);
            rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor: pixel presentations (BSP rise or BCK edge) and frame totals at frame_done
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (intb && !intb_p) begin
                if (gap_q.size() > 0) check("intb_gap", gap, gap_q.pop_front());
                len = 0; n_gck = 0; n_bck = 0; n_bsp = 0; n_gen = 0; n_pop = 0; n_stall = 0;
            end
            if (!intb) gap = intb_p ? 1 : gap + 1;
            if (intb) begin
                len++;
                if (gck != gck_p) n_gck++;
                if (bck != bck_p) n_bck++;
                if (bsp && !bsp_p) n_bsp++;
                if (gen && !gen_p) n_gen++;
                if (fifo_rd) n_pop++;
                if (stall) n_stall++;
                if (pix_en && ((bsp && !bsp_p) || (bck != bck_p))) begin
                    if (pix_q.size() == 0) check("pix_extra", 1, 0);
                    else check("rgb", int'(rgb), int'(pix_q.pop_front()));
                end
            end
            if (done) begin
                if (frm_q.size() == 0) check("frame_extra", 1, 0);
                else begin
                    f = frm_q.pop_front();
                    check("frame_len", len, f.len);
                    check("gck_toggles", n_gck, f.gck);
                    check("bck_toggles", n_bck, f.bck);
                    check("bsp_pulses", n_bsp, f.bsp);
                    check("gen_pulses", n_gen, f.gen);
                    check("pops", n_pop, f.pops);
                    check("stall_clocks", n_stall, f.stall);
                    check("underrun", int'(underrun), f.und);
                end
            end
            intb_p = intb; gck_p = gck; bck_p = bck; bsp_p = bsp; gen_p = gen;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pins", int'({intb, gsp, gck, gen, bsp, bck}), 0);
        check("rst_rgb", int'(rgb), 0);
        check("rst_status", int'({busy, done, stall, underrun, fifo_rd}), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Nominal frame, words 1..12
        load(1, 12, 1'b1);
        push_frame(50, 12, 0, 0);
        pulse_req();
        wait_done("t1_done", 300);
        repeat (4) @(posedge clk);

`ifndef MLCD_UNDERRUN_FILL_EN
        // FIFO dry for 6 clocks at word 2 of line 1
        block_at = pop_total + 6;
        load(13, 12, 1'b1);
        push_frame(56, 12, 6, 0);
        pulse_req();
        wait_done("t2_done", 300);
        block_at = -1;
        repeat (4) @(posedge clk);
`endif

        // Reset in the middle of DATA
        pix_en = 1'b0;
        n = pop_total + 6;
        load(40, 12, 1'b0);
        pulse_req();
        for (int i = 0; i < 200 && pop_total < n; i++) @(negedge clk);
        check("t3_reached_data", int'(pop_total >= n), 1);
        check("t3_busy_before", int'(busy), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("t3_rst_pins", int'({intb, gsp, gck, gen, bsp, bck}), 0);
        check("t3_rst_rgb", int'(rgb), 0);
        check("t3_rst_busy", int'(busy), 0);
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        pix_en = 1'b1;
        load(61, 12, 1'b1);
        push_frame(50, 12, 0, 0);
        pulse_req();
        wait_done("t3_fresh_done", 300);
        repeat (4) @(posedge clk);

        // Request held with an empty FIFO: no start until words arrive
        @(posedge clk); #1 req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_idle_busy", int'(busy), 0);
        end
        push_frame(50, 12, 0, 0);
        load(81, 12, 1'b1);
        wait_done("t4_done", 300);
        #1 req = 1'b0;
        repeat (4) @(posedge clk);

        // Back-to-back frames with request held
        load(101, 24, 1'b1);
        push_frame(50, 12, 0, 0);
        push_frame(50, 12, 0, 0);
        #1 req = 1'b1;
        wait_done("t5_first_done", 300);
        gap_q.push_back(2);
        repeat (4) @(negedge clk);
        req = 1'b0;
        wait_done("t5_second_done", 300);
        repeat (4) @(posedge clk);

`ifdef MLCD_UNDERRUN_FILL_EN
        // Only 10 words: last two painted white, flag sticky until next start
        load(131, 10, 1'b1);
        pix_q.push_back(6'h3F);
        pix_q.push_back(6'h3F);
        push_frame(50, 10, 0, 1);
        pulse_req();
        wait_done("t6_done", 300);
        repeat (4) @(negedge clk);
        check("t6_underrun_sticky", int'(underrun), 1);
        load(141, 12, 1'b1);
        push_frame(50, 12, 0, 0);
        pulse_req();
        wait_done("t6_clear_done", 300);
        repeat (4) @(posedge clk);
`endif

        repeat (4) @(negedge clk);
        check("busy_end", int'(busy), 0);
        check("pix_left", pix_q.size(), 0);
        check("frames_left", frm_q.size(), 0);
        check("gaps_left", gap_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlcd_scan_sequencer.md
Name: mlcd_scan_sequencer

Overview:
- Frame-scan controller for the memory-LCD datapath.
- Pops 6-bit RGB words from the SPI-fed pixel FIFO, which is first-word-fall-through.
- Sequences the panel timing pins INTB, GSP, GCK, BSP, BCK, GEN and RGB for one full frame per request.
- Sits between the async pixel FIFO read port and the LCD output pads. The VCOM/VA/VB generator is a separate, independent block.

Parameters:
- H_WORDS, 240: FIFO words (BCK transfers) per gate line.
- V_LINES, 320: gate lines per frame.
- DIV, 4: clocks per timing tick; legal values are 2 and up.
- GEN_TICKS, 2: width of the GEN pulse, in ticks.
- RGB_W, 6: pixel word width.

Ports:
- i_clk, in, 1: system clock.
- i_reset_n, in, 1: asynchronous active-low reset.
- i_frame_req, in, 1: level request to scan one frame.
- i_fifo_rdata, in, RGB_W: FIFO head word; valid while i_fifo_rempty is 0.
- i_fifo_rempty, in, 1: FIFO empty flag.
- o_fifo_rd, out, 1: pop strobe, one clock wide.
- o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck, out, 1 each: panel timing pins.
- o_rgb, out, RGB_W: panel pixel data.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_frame_done, out, 1: one-clock pulse at the end of a frame.
- o_stall, out, 1: high while DATA is waiting on an empty FIFO.
- o_underrun, out, 1: sticky underrun flag (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock domain, i_clk.
  - Reset is asynchronous and active-low on i_reset_n, with synchronous deassert handled upstream.
  - During reset all outputs are 0, all counters are 0, and the state is IDLE.
  - Reset mid-frame drops the pins to 0 immediately. There is no frame resumption afterwards.
- Tick:
  - The prescaler counts 0..DIV-1.
  - tick is high for one clock when the count equals DIV-1.
  - Every state change and every pin change happens on a tick clock only. o_fifo_rd and o_frame_done are also pulsed on tick clocks.
- State sequence:
  - IDLE: on a tick where i_frame_req=1 and i_fifo_rempty=0, set o_intb<=1 and go to INTB.
  - INTB, 1 tick: o_gsp<=1, go to GSP.
  - GSP, 1 tick: line<=0, go to LINE.
  - LINE, 1 tick: toggle o_gck. Set o_gsp<=0 if line==0. word<=0, go to DATA.
  - DATA, H_WORDS ticks:
    - If i_fifo_rempty=0: o_rgb<=i_fifo_rdata and o_fifo_rd=1 for that clock.
    - o_bsp=1 for word 0 only.
    - o_bck toggles for word 1 and later.
    - word++. After word H_WORDS-1, go to GEN.
  - GEN, GEN_TICKS ticks: o_gen=1 and o_rgb held. On exit o_gen<=0 and line++. Go to TAIL if line==V_LINES, otherwise go to LINE.
  - TAIL, 2 ticks:
    - First tick: toggle o_gck.
    - Second tick: o_intb<=0, o_gck<=0, o_bck<=0, o_frame_done=1, go to IDLE.
- Per-frame totals: V_LINES+1 GCK toggles, V_LINES*(H_WORDS-1) BCK toggles, and V_LINES*H_WORDS pops.
- Frame length is 4 + V_LINES*(1+H_WORDS+GEN_TICKS) ticks, excluding stall ticks.
- Underflow in DATA with the feature off: when the FIFO is empty on a tick, all pins and counters hold, there is no pop, and o_stall=1. Resume on the first tick with the FIFO non-empty.
- Handshake: a pop happens only on a tick clock, and only when i_fifo_rempty=0 in that same clock.
- Simultaneous events:
  - i_frame_req is ignored while o_busy is high.
  - A request still held at TAIL exit starts the next frame no earlier than the next tick.
- Width rules: counters are $clog2 sized. Line and word compares use exact equality, with no wrap beyond the terminal value.

Optional Feature:
- Macro: MLCD_UNDERRUN_FILL_EN.
- Defined:
  - An empty FIFO in DATA does not stall.
  - o_rgb<={RGB_W{1'b1}} (white), there is no pop, and BCK/BSP advance as normal.
  - o_underrun is set and stays set until reset or the next IDLE->INTB start.
  - o_stall stays 0.
- Undefined: stall behaviour as above, and o_underrun is tied to 0.

Decomposition:
- Package mlcd_pkg holds:
  - the state enum: IDLE, INTB, GSP, LINE, DATA, GEN, TAIL;
  - RGB_W;
  - the default geometry constants H_WORDS_DEF and V_LINES_DEF;
  - FILL_WHITE.
- Sub-module mlcd_tick_gen holds the DIV prescaler and outputs tick.

Test Plan (H_WORDS=4, V_LINES=3, DIV=2, GEN_TICKS=2):
- Prefilled FIFO, 12 words 1..12, i_frame_req pulsed:
  - frame_done at 50 clocks from the start tick;
  - 4 GCK toggles, 9 BCK toggles, 3 BSP and 3 GEN pulses, 12 pops;
  - rgb sequence 1..12.
- FIFO empty for 6 clocks at word 2 of line 1:
  - o_stall high for 3 ticks;
  - BCK frozen;
  - frame length 56 clocks;
  - no data lost or duplicated.
- i_reset_n low in the middle of DATA: all pins 0 in the same clock, o_busy=0; after release, the next request scans a full fresh frame.
- i_frame_req held high with a continuous FIFO: back-to-back frames, with INTB low for exactly 1 tick between them.
- i_frame_req=1 with the FIFO empty in IDLE: no start and o_busy=0 until a word arrives.
- With MLCD_UNDERRUN_FILL_EN, FIFO holding 10 words: the last 2 words output as 6'h3F, o_underrun=1, frame length 50 clocks.
